// File: rtl/lpad_elp_ctrl.sv
// lpad_elp_ctrl: Zicfilp landing-pad expectation tracker with fault handshake
// Ports: clk_i/rst_i (sync, active-high); commit_* describe the committing
// instruction; trap_i/xret_i/spelp_i drive ELP save/restore via xPELP;
// elp_o feeds the branch unit; lp_ex_* is the ready/valid fault exception;
// complete_cfi_o reports the check outcome (00 fault, 01 none, 10 off, 11 ok).
module lpad_elp_ctrl #(
  parameter int VLEN    = 64,
  parameter int XLEN    = 64,
  parameter int LABEL_W = 20
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lpad_en_i,
  input  logic               commit_valid_i,
  input  logic [VLEN-1:0]    commit_pc_i,
  input  logic               commit_is_jalr_i,
  input  logic [4:0]         commit_rs1_i,
  input  logic               commit_is_lpad_i,
  input  logic [LABEL_W-1:0] commit_lpad_label_i,
  input  logic [LABEL_W-1:0] x7_label_i,
  input  logic               trap_i,
  input  logic               xret_i,
  input  logic               spelp_i,
  output logic               elp_o,
  output logic               spelp_o,
  output logic               spelp_we_o,
  output logic               lp_ex_valid_o,
  input  logic               lp_ex_ready_i,
  output logic [XLEN-1:0]    lp_ex_tval_o,
  output logic [VLEN-1:0]    lp_ex_pc_o,
  output logic [1:0]         complete_cfi_o
);
  typedef enum logic [1:0] {IDLE, EXPECT, FAULT} state_e;
  state_e state_q, state_d;
  logic elp_q, elp_d, valid_q, valid_d, spelp_q, spelp_d, we_q, we_d;
  logic match_q, match_d, dis_q, dis_d, lp_match, fault_entry;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [VLEN-1:0] pc_q, pc_d;
  always_comb begin
    lp_match = commit_is_lpad_i &
               (commit_lpad_label_i == '0 | commit_lpad_label_i == x7_label_i);
    state_d = state_q;
    match_d = 1'b0;
    if (trap_i) state_d = IDLE;
    else if (xret_i) state_d = (spelp_i & lpad_en_i) ? EXPECT : IDLE;
    else if (!lpad_en_i) state_d = IDLE;
    else if (state_q == EXPECT && commit_valid_i) begin
      state_d = lp_match ? IDLE : FAULT;
      match_d = lp_match;
    end
    else if (state_q == IDLE && commit_valid_i && commit_is_jalr_i && commit_rs1_i != 5'd7)
      state_d = EXPECT;
    else if (state_q == FAULT && valid_q && lp_ex_ready_i) state_d = IDLE;
    fault_entry = state_q == EXPECT && state_d == FAULT;
    elp_d = state_d != IDLE;
    valid_d = state_d == FAULT;
    pc_d = fault_entry ? commit_pc_i : pc_q;
    tval_d = fault_entry ? XLEN'(2) : tval_q;
    we_d = trap_i | xret_i;
    // a trap saves the current ELP; xRET clears xPELP
    spelp_d = trap_i & elp_q;
    dis_d = ~lpad_en_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      elp_q   <= 1'b0;
      valid_q <= 1'b0;
      spelp_q <= 1'b0;
      we_q    <= 1'b0;
      match_q <= 1'b0;
      dis_q   <= 1'b0;
      tval_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      elp_q   <= elp_d;
      valid_q <= valid_d;
      spelp_q <= spelp_d;
      we_q    <= we_d;
      match_q <= match_d;
      dis_q   <= dis_d;
      tval_q  <= tval_d;
      pc_q    <= pc_d;
    end
  end
  assign elp_o          = elp_q;
  assign spelp_o        = spelp_q;
  assign spelp_we_o     = we_q;
  assign lp_ex_valid_o  = valid_q;
  assign lp_ex_tval_o   = tval_q;
  assign lp_ex_pc_o     = pc_q;
  assign complete_cfi_o = dis_q ? 2'b10 : match_q ? 2'b11 : state_q == FAULT ? 2'b00 : 2'b01;
endmodule

// File: tb/tb_lpad_elp_ctrl.sv
// tb_lpad_elp_ctrl: directed + random check of lpad_elp_ctrl against a spec-level model
module tb_lpad_elp_ctrl;
  logic clk_i = 1'b0;
  logic rst_i, lpad_en_i, commit_valid_i, commit_is_jalr_i, commit_is_lpad_i;
  logic trap_i, xret_i, spelp_i, lp_ex_ready_i;
  logic [63:0] commit_pc_i;
  logic [4:0] commit_rs1_i;
  logic [19:0] commit_lpad_label_i, x7_label_i;
  logic elp_o, spelp_o, spelp_we_o, lp_ex_valid_o;
  logic [63:0] lp_ex_tval_o, lp_ex_pc_o;
  logic [1:0] complete_cfi_o;
  int n_chk = 0, n_err = 0;
  logic m_elp, m_fault, m_spelp, m_we;
  logic [63:0] m_pc, m_tval;
  logic [1:0] m_cfi;

  lpad_elp_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .lpad_en_i(lpad_en_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_is_jalr_i(commit_is_jalr_i), .commit_rs1_i(commit_rs1_i),
    .commit_is_lpad_i(commit_is_lpad_i), .commit_lpad_label_i(commit_lpad_label_i),
    .x7_label_i(x7_label_i), .trap_i(trap_i), .xret_i(xret_i), .spelp_i(spelp_i),
    .elp_o(elp_o), .spelp_o(spelp_o), .spelp_we_o(spelp_we_o),
    .lp_ex_valid_o(lp_ex_valid_o), .lp_ex_ready_i(lp_ex_ready_i),
    .lp_ex_tval_o(lp_ex_tval_o), .lp_ex_pc_o(lp_ex_pc_o), .complete_cfi_o(complete_cfi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference: the architectural ELP bit, a pending-fault flag and the
  // captured fault record, advanced once per clock from the rules.
  task automatic model_update();
    logic matched;
    matched = 1'b0;
    if (rst_i) begin
      m_elp = 0; m_fault = 0; m_spelp = 0; m_we = 0; m_pc = 0; m_tval = 0; m_cfi = 2'b01;
      return;
    end
    m_we = 0;
    m_spelp = 0;
    if (trap_i) begin
      m_we = 1; m_spelp = m_elp; m_elp = 0; m_fault = 0;
    end else if (xret_i) begin
      m_we = 1; m_elp = spelp_i & lpad_en_i; m_fault = 0;
    end else if (!lpad_en_i) begin
      m_elp = 0; m_fault = 0;
    end else if (m_fault) begin
      if (lp_ex_ready_i) begin m_fault = 0; m_elp = 0; end
    end else if (m_elp) begin
      if (commit_valid_i) begin
        if (commit_is_lpad_i && (commit_lpad_label_i == 0 || commit_lpad_label_i == x7_label_i)) begin
          m_elp = 0; matched = 1;
        end else begin
          m_fault = 1; m_pc = commit_pc_i; m_tval = 2;
        end
      end
    end else if (commit_valid_i && commit_is_jalr_i && commit_rs1_i != 7) m_elp = 1;
    m_cfi = !lpad_en_i ? 2'b10 : matched ? 2'b11 : m_fault ? 2'b00 : 2'b01;
  endtask

  task automatic step();
    @(posedge clk_i);
    model_update();
    #1;
    chk("elp", elp_o, m_elp);
    chk("ex_valid", lp_ex_valid_o, m_fault);
    chk("ex_tval", lp_ex_tval_o, m_tval);
    chk("ex_pc", lp_ex_pc_o, m_pc);
    chk("spelp", spelp_o, m_spelp);
    chk("spelp_we", spelp_we_o, m_we);
    chk("cfi", complete_cfi_o, m_cfi);
    rst_i = 0; commit_valid_i = 0; commit_is_jalr_i = 0; commit_is_lpad_i = 0;
    trap_i = 0; xret_i = 0; commit_rs1_i = 0; commit_lpad_label_i = 0;
  endtask

  task automatic do_jalr(input logic [4:0] rs1);
    commit_valid_i = 1; commit_is_jalr_i = 1; commit_rs1_i = rs1; commit_pc_i = 64'h1000;
    step();
  endtask

  task automatic do_commit(input logic lpad, input logic [19:0] label, input logic [63:0] pc);
    commit_valid_i = 1; commit_is_lpad_i = lpad; commit_lpad_label_i = label; commit_pc_i = pc;
    step();
  endtask

  initial begin
    rst_i = 1; lpad_en_i = 1; commit_valid_i = 0; commit_is_jalr_i = 0; commit_is_lpad_i = 0;
    trap_i = 0; xret_i = 0; spelp_i = 0; lp_ex_ready_i = 0; commit_pc_i = 0;
    commit_rs1_i = 0; commit_lpad_label_i = 0; x7_label_i = 0;
    m_elp = 0; m_fault = 0; m_spelp = 0; m_we = 0; m_pc = 0; m_tval = 0; m_cfi = 2'b01;
    rst_i = 1; step();
    chk("rst_cfi", complete_cfi_o, 2'b01);
    chk("rst_elp", elp_o, 0);
    // JALR then LPAD label 0 three cycles later
    do_jalr(5);
    chk("jalr_elp", elp_o, 1);
    step(); step();
    chk("expect_hold", elp_o, 1);
    do_commit(1, 0, 64'h1004);
    chk("lpad0_cfi", complete_cfi_o, 2'b11);
    chk("lpad0_elp", elp_o, 0);
    step();
    chk("pulse_one", complete_cfi_o, 2'b01);
    // mismatch on ADD, slow handshake
    do_jalr(10);
    do_commit(0, 0, 64'h2000);
    chk("fault_valid", lp_ex_valid_o, 1);
    chk("fault_tval", lp_ex_tval_o, 2);
    chk("fault_pc", lp_ex_pc_o, 64'h2000);
    for (int i = 0; i < 3; i++) begin
      do_commit(1, 0, 64'h3000 + i);
      chk("fault_stable_pc", lp_ex_pc_o, 64'h2000);
      chk("fault_cfi", complete_cfi_o, 2'b00);
    end
    lp_ex_ready_i = 1; step();
    chk("hs_valid", lp_ex_valid_o, 0);
    chk("hs_elp", elp_o, 0);
    lp_ex_ready_i = 0;
    // x7 label matching
    x7_label_i = 20'h12345;
    do_jalr(1);
    do_commit(1, 20'h12345, 64'h4000);
    chk("x7_match", complete_cfi_o, 2'b11);
    do_jalr(1);
    do_commit(1, 20'h12346, 64'h4100);
    chk("x7_mismatch", lp_ex_valid_o, 1);
    lp_ex_ready_i = 1; step(); lp_ex_ready_i = 0;
    // software-guarded JALR via x7
    do_jalr(7);
    chk("x7_guard_elp", elp_o, 0);
    do_commit(0, 0, 64'h5000);
    chk("x7_guard_nofault", lp_ex_valid_o, 0);
    chk("x7_guard_cfi", complete_cfi_o, 2'b01);
    // trap saves ELP, xret restores it
    do_jalr(5);
    trap_i = 1; step();
    chk("trap_we", spelp_we_o, 1);
    chk("trap_spelp", spelp_o, 1);
    chk("trap_elp", elp_o, 0);
    step();
    chk("trap_we_once", spelp_we_o, 0);
    xret_i = 1; spelp_i = 1; step(); spelp_i = 0;
    chk("xret_elp", elp_o, 1);
    chk("xret_we", spelp_we_o, 1);
    chk("xret_spelp", spelp_o, 0);
    // disable while expecting
    lpad_en_i = 0; do_commit(0, 0, 64'h6000);
    chk("dis_elp", elp_o, 0);
    chk("dis_cfi", complete_cfi_o, 2'b10);
    chk("dis_nofault", lp_ex_valid_o, 0);
    step();
    chk("dis_cfi_hold", complete_cfi_o, 2'b10);
    lpad_en_i = 1; step();
    // trap together with mismatch, trap together with handshake
    do_jalr(5);
    trap_i = 1; do_commit(0, 0, 64'h7000);
    chk("trap_vs_fault", lp_ex_valid_o, 0);
    do_jalr(5);
    do_commit(0, 0, 64'h7100);
    trap_i = 1; lp_ex_ready_i = 1; step(); lp_ex_ready_i = 0;
    chk("trap_hs_we", spelp_we_o, 1);
    step();
    chk("trap_hs_we_once", spelp_we_o, 0);
    // reset during fault
    do_jalr(5);
    do_commit(0, 0, 64'h8000);
    rst_i = 1; step();
    chk("rst_fault_valid", lp_ex_valid_o, 0);
    chk("rst_fault_pc", lp_ex_pc_o, 0);
    chk("rst_fault_tval", lp_ex_tval_o, 0);
    step(); step();
    chk("rst_no_reassert", lp_ex_valid_o, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [19:0] x7s[3];
      x7s[0] = 20'h0; x7s[1] = 20'h12345; x7s[2] = 20'hABCDE;
      x7_label_i = x7s[$urandom_range(0, 2)];
      commit_valid_i = $urandom_range(0, 1);
      commit_is_jalr_i = $urandom_range(0, 3) == 0;
      commit_rs1_i = $urandom_range(0, 3) == 0 ? 5'd7 : 5'($urandom_range(0, 31));
      commit_is_lpad_i = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 3))
        0: commit_lpad_label_i = 0;
        1: commit_lpad_label_i = x7_label_i;
        default: commit_lpad_label_i = 20'($urandom_range(0, 20'hFFFFF));
      endcase
      commit_pc_i = {32'($urandom), 32'($urandom)} & ~64'h1;
      trap_i = $urandom_range(0, 29) == 0;
      xret_i = $urandom_range(0, 29) == 0;
      spelp_i = $urandom_range(0, 1);
      lpad_en_i = $urandom_range(0, 15) != 0;
      lp_ex_ready_i = $urandom_range(0, 1);
      rst_i = $urandom_range(0, 199) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lpad_elp_ctrl.md
# lpad_elp_ctrl

Landing-pad expectation controller for the SSLP (Zicfilp) extension. It tracks the ELP state across committed control flow and arms LP_EXPECTED when an indirect jump commits. It checks that the next committed instruction is a matching LPAD, and raises a software-check exception with a ready/valid handshake on mismatch. It sits beside commit, feeds `elp_o` back to the branch unit, and saves/restores ELP around traps and xRET via the CSR file.

## Interface
- `VLEN`, default 64: virtual address width.
- `XLEN`, default 64: register width, used for tval.
- `LABEL_W`, default 20: LPAD label width, taken from instruction bits [31:12].

- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, synchronous, active-high.
- `lpad_en_i`  in  1: xLPE for the current privilege level.
- `commit_valid_i`  in  1: one instruction commits this cycle.
- `commit_pc_i`  in  VLEN: PC of the committing instruction.
- `commit_is_jalr_i`  in  1: committing instruction is an indirect JALR/C.JR/C.JALR.
- `commit_rs1_i`  in  5: rs1 index of the committing JALR.
- `commit_is_lpad_i`  in  1: committing instruction is LPAD.
- `commit_lpad_label_i`  in  LABEL_W: LPAD immediate label.
- `x7_label_i`  in  LABEL_W: x7[31:12] at commit.
- `trap_i`  in  1: trap taken this cycle.
- `xret_i`  in  1: MRET/SRET committed this cycle.
- `spelp_i`  in  1: xPELP value read from the CSR file.
- `elp_o`  out  1: 1 = LP_EXPECTED, 0 = NO_LP_EXPECTED.
- `spelp_o`  out  1: ELP value to save into xPELP.
- `spelp_we_o`  out  1: write strobe for xPELP.
- `lp_ex_valid_o`  out  1: landing-pad fault exception pending.
- `lp_ex_ready_i`  in  1: exception accepted by commit/CSR.
- `lp_ex_tval_o`  out  XLEN: fault tval, always 2 (LANDING_PAD_FAULT).
- `lp_ex_pc_o`  out  VLEN: PC of the faulting instruction.
- `complete_cfi_o`  out  2: 00 mismatch, 01 no check, 10 disabled, 11 match.

## Operation
- State machine with states IDLE, EXPECT, FAULT. `elp_o` is 1 in EXPECT and FAULT.
- Priority in every state:
  1. Reset.
  2. `trap_i`.
  3. `xret_i`.
  4. `lpad_en_i` low.
  5. Commit event.
- IDLE:
  - On `commit_valid_i & commit_is_jalr_i & lpad_en_i & (commit_rs1_i != 7)`, go to EXPECT.
  - A JALR with rs1 = x7 is software-guarded and stays in IDLE.
- EXPECT:
  - On `commit_valid_i`, evaluate match = `commit_is_lpad_i & (commit_lpad_label_i == 0 | commit_lpad_label_i == x7_label_i)`.
  - Match: go to IDLE and pulse `complete_cfi_o` = 11.
  - No match (including another JALR committing): go to FAULT, capture `commit_pc_i` into `lp_ex_pc_o`, assert `lp_ex_valid_o`.
  - While no commit occurs, stay in EXPECT.
- FAULT:
  - Hold `lp_ex_valid_o`, tval and pc stable until `lp_ex_valid_o & lp_ex_ready_i`, then go to IDLE.
  - Commits are ignored in FAULT.
- `trap_i` in any state:
  - `spelp_o` = `elp_o`, `spelp_we_o` = 1 for one cycle, next state IDLE.
  - The trap supersedes a pending fault, so `lp_ex_valid_o` drops.
- `xret_i`:
  - Next state is EXPECT if `spelp_i & lpad_en_i`, else IDLE.
  - `spelp_o` = 0, `spelp_we_o` = 1 for one cycle, which clears xPELP.
- `lpad_en_i` low:
  - Forces IDLE next cycle; no fault is raised.
  - `complete_cfi_o` = 10 for as long as it stays low.
- `complete_cfi_o` default:
  - 01 in IDLE and EXPECT when no pulse is active.
  - 00 while in FAULT.
  - 10 while disabled; this overrides all other encodings.

## Timing
- All outputs are registered except `complete_cfi_o`, which is decoded from registered state and registered pulse flags.
- Reset values:
  - State IDLE, `elp_o` = 0.
  - `lp_ex_valid_o` = 0, `lp_ex_tval_o` = 0, `lp_ex_pc_o` = 0.
  - `spelp_o` = 0, `spelp_we_o` = 0.
  - `complete_cfi_o` = 01.
- Latencies, for an event at cycle t:
  - JALR commit at t gives `elp_o` = 1 at t+1.
  - LPAD checked at t gives `complete_cfi_o` = 11 at t+1 for exactly one cycle, with `elp_o` = 0 at t+1.
  - Mismatch at t gives `lp_ex_valid_o` = 1 at t+1, with tval = 2.
  - Handshake at t gives `lp_ex_valid_o` = 0 at t+1.
- Ready before valid is allowed. Valid must not depend on ready.
- Same-cycle events:
  - `trap_i` and fault detection together: the trap wins and no exception is raised.
  - `trap_i` and handshake together: IDLE, with a single `spelp_we_o` pulse.
- Reset mid-FAULT drops the exception at the next edge without a handshake.

## Test plan
- JALR rs1 = 5 commits, then LPAD with label 0 commits at t+3 -> `elp_o` is 1 for cycles t+1..t+3, `complete_cfi_o` = 11 at t+4, `elp_o` = 0 at t+4.
- JALR rs1 = 10, then ADD commits -> `lp_ex_valid_o` = 1 with tval = 2 and pc = ADD PC. `lp_ex_ready_i` held low for 3 cycles: outputs stay stable, `complete_cfi_o` = 00. Ready = 1: next cycle IDLE, `elp_o` = 0.
- `x7_label_i` = 0x12345, LPAD label 0x12345 -> match (11). LPAD label 0x12346 -> fault.
- JALR rs1 = 7 -> `elp_o` stays 0. Following non-LPAD commit -> no fault, `complete_cfi_o` = 01.
- Two scenarios:
  - In EXPECT, `trap_i` -> `spelp_we_o` = 1 and `spelp_o` = 1, then IDLE. Later `xret_i` with `spelp_i` = 1 -> `elp_o` = 1, `spelp_we_o` pulse with `spelp_o` = 0.
  - `lpad_en_i` = 0 in EXPECT -> IDLE, `complete_cfi_o` = 10, no exception.
- Assert `rst_i` during FAULT -> next cycle all outputs at reset values. `lp_ex_valid_o` never reasserts without a new mismatch.
